// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg
//   Shared definitions for the multicycle controller: FSM state encoding,
//   opcode constants, ULAControl operation codes, immediate-format codes and
//   the datapath mux select codes (ULASrcA, ULASrcB, ResultSrc).
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH,
        DECODE,
        EXEC_R,
        EXEC_I,
        MEM_ADR,
        MEM_RD,
        MEM_WB,
        MEM_WR,
        ALU_WB,
        BRANCH,
        TRAP
    } state_t;

    // Opcodes
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_ADDI   = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    // Funct7 values accepted for R-type
    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_SUB  = 7'b0100000;

    // ULAControl operations
    localparam logic [2:0] ULA_ADD = 3'b000;
    localparam logic [2:0] ULA_SUB = 3'b001;
    localparam logic [2:0] ULA_AND = 3'b010;
    localparam logic [2:0] ULA_OR  = 3'b011;
    localparam logic [2:0] ULA_XOR = 3'b100;
    localparam logic [2:0] ULA_SLT = 3'b101;

    // ImmSrc formats
    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;

    // ULASrcA selects
    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    // ULASrcB selects
    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    // ResultSrc selects
    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_MEM    = 2'b01;
    localparam logic [1:0] RES_ULA    = 2'b10;

    // Immediate format implied by an opcode (I-format for everything else).
    function automatic logic [1:0] imm_sel(input logic [6:0] op);
        case (op)
            OP_STORE:  imm_sel = IMM_S;
            OP_BRANCH: imm_sel = IMM_B;
            default:   imm_sel = IMM_I;
        endcase
    endfunction

endpackage

// File: rtl/ula_decoder.sv
// ula_decoder
//   Combinational R-type function decode.
//   funct3, funct7 : IR function fields
//   ula_control    : ULA operation (ADD when illegal)
//   illegal        : encoding is not a supported R-type operation
module ula_decoder
    import mc_ctrl_pkg::*;
(
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    output logic [2:0] ula_control,
    output logic       illegal
);

    always_comb begin
        ula_control = ULA_ADD;
        illegal     = 1'b0;
        if (funct7 == F7_BASE) begin
            case (funct3)
                3'b000:  ula_control = ULA_ADD;
                3'b111:  ula_control = ULA_AND;
                3'b110:  ula_control = ULA_OR;
                3'b100:  ula_control = ULA_XOR;
                3'b010:  ula_control = ULA_SLT;
                default: illegal     = 1'b1;
            endcase
        end else if (funct7 == F7_SUB && funct3 == 3'b000) begin
            ula_control = ULA_SUB;
        end else begin
            illegal = 1'b1;
        end
    end

endmodule

// File: rtl/multicycle_control.sv
// multicycle_control
//   Multicycle RISC-V subset controller (ADD/SUB/AND/OR/XOR/SLT, ADDI, LB,
//   SB, BEQ). Unsupported encodings halt in TRAP until reset.
//   clk, rst_n           : clock, async active-low reset
//   OP, Funct3, Funct7   : instruction register fields
//   Zero                 : ULA zero flag (branch compare)
//   mem_ready            : memory completes current access this cycle
//   mem_req, AdrSrc      : memory request and address select
//   PCWrite, IRWrite, RegWrite, MemWrite : datapath write strobes
//   ULASrcA, ULASrcB, ResultSrc, ImmSrc, ULAControl : datapath selects
//   instr_done           : pulse in final cycle of each instruction
//   instr_count          : retired-instruction counter (wraps)
//   trap                 : halted on unsupported instruction
module multicycle_control
    import mc_ctrl_pkg::*;
#(
    parameter int unsigned COUNT_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [6:0]         OP,
    input  logic [2:0]         Funct3,
    input  logic [6:0]         Funct7,
    input  logic               Zero,
    input  logic               mem_ready,
    output logic               mem_req,
    output logic               PCWrite,
    output logic               IRWrite,
    output logic               RegWrite,
    output logic               MemWrite,
    output logic               AdrSrc,
    output logic [1:0]         ULASrcA,
    output logic [1:0]         ULASrcB,
    output logic [1:0]         ResultSrc,
    output logic [1:0]         ImmSrc,
    output logic [2:0]         ULAControl,
    output logic               instr_done,
    output logic [COUNT_W-1:0] instr_count,
    output logic               trap
);

    state_t     state;
    state_t     decode_next;
    logic [2:0] r_ula;
    logic       r_illegal;

    ula_decoder u_ula_decoder (
        .funct3      (Funct3),
        .funct7      (Funct7),
        .ula_control (r_ula),
        .illegal     (r_illegal)
    );

    // Dispatch target out of DECODE; anything not recognised halts.
    always_comb begin
        decode_next = TRAP;
        case (OP)
            OP_R:      decode_next = r_illegal ? TRAP : EXEC_R;
            OP_ADDI:   decode_next = (Funct3 == 3'b000) ? EXEC_I  : TRAP;
            OP_LOAD,
            OP_STORE:  decode_next = (Funct3 == 3'b000) ? MEM_ADR : TRAP;
            OP_BRANCH: decode_next = (Funct3 == 3'b000) ? BRANCH  : TRAP;
            default:   decode_next = TRAP;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= FETCH;
            instr_count <= '0;
        end else begin
            if (instr_done)
                instr_count <= instr_count + COUNT_W'(1);
            case (state)
                FETCH:   if (mem_ready) state <= DECODE;
                DECODE:  state <= decode_next;
                EXEC_R,
                EXEC_I:  state <= ALU_WB;
                MEM_ADR: state <= (OP == OP_STORE) ? MEM_WR : MEM_RD;
                MEM_RD:  if (mem_ready) state <= MEM_WB;
                MEM_WR:  if (mem_ready) state <= FETCH;
                MEM_WB,
                ALU_WB,
                BRANCH:  state <= FETCH;
                TRAP:    state <= TRAP;
                default: state <= FETCH;
            endcase
        end
    end

    // Outputs decode from the state register; the strobes that follow
    // mem_ready/Zero must respond in the same cycle, so they cannot be
    // flopped. Gating with rst_n keeps everything quiet while reset is held.
    always_comb begin
        mem_req    = 1'b0;
        PCWrite    = 1'b0;
        IRWrite    = 1'b0;
        RegWrite   = 1'b0;
        MemWrite   = 1'b0;
        AdrSrc     = 1'b0;
        ULASrcA    = SRCA_PC;
        ULASrcB    = SRCB_RS2;
        ResultSrc  = RES_ALUOUT;
        ImmSrc     = IMM_I;
        ULAControl = ULA_ADD;
        instr_done = 1'b0;
        trap       = 1'b0;
        if (rst_n) begin
            case (state)
                FETCH: begin
                    mem_req   = 1'b1;
                    ULASrcB   = SRCB_FOUR;
                    ResultSrc = RES_ULA;
                    IRWrite   = mem_ready;
                    PCWrite   = mem_ready;
                end
                DECODE: begin
                    ULASrcA = SRCA_OLDPC;
                    ULASrcB = SRCB_IMM;
                    ImmSrc  = imm_sel(OP);
                end
                EXEC_R: begin
                    ULASrcA    = SRCA_RS1;
                    ULASrcB    = SRCB_RS2;
                    ULAControl = r_ula;
                end
                EXEC_I: begin
                    ULASrcA = SRCA_RS1;
                    ULASrcB = SRCB_IMM;
                end
                MEM_ADR: begin
                    ULASrcA = SRCA_RS1;
                    ULASrcB = SRCB_IMM;
                    ImmSrc  = (OP == OP_STORE) ? IMM_S : IMM_I;
                end
                MEM_RD: begin
                    mem_req = 1'b1;
                    AdrSrc  = 1'b1;
                end
                MEM_WB: begin
                    ResultSrc  = RES_MEM;
                    RegWrite   = 1'b1;
                    instr_done = 1'b1;
                end
                MEM_WR: begin
                    mem_req    = 1'b1;
                    AdrSrc     = 1'b1;
                    MemWrite   = 1'b1;
                    instr_done = mem_ready;
                end
                ALU_WB: begin
                    ResultSrc  = RES_ALUOUT;
                    RegWrite   = 1'b1;
                    instr_done = 1'b1;
                end
                BRANCH: begin
                    ULASrcA    = SRCA_RS1;
                    ULASrcB    = SRCB_RS2;
                    ULAControl = ULA_SUB;
                    ResultSrc  = RES_ALUOUT;
                    PCWrite    = Zero;
                    instr_done = 1'b1;
                end
                TRAP: trap = 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control
//   Directed per-cycle stimulus; each cycle's hand-derived expected control
//   vector and counter value is queued and checked by a separate monitor.
module tb_multicycle_control;

    localparam int unsigned CW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [6:0]    OP;
    logic [2:0]    Funct3;
    logic [6:0]    Funct7;
    logic          Zero;
    logic          mem_ready;
    logic          mem_req, PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc;
    logic [1:0]    ULASrcA, ULASrcB, ResultSrc, ImmSrc;
    logic [2:0]    ULAControl;
    logic          instr_done;
    logic [CW-1:0] instr_count;
    logic          trap;

    multicycle_control #(.COUNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .OP(OP), .Funct3(Funct3), .Funct7(Funct7),
        .Zero(Zero), .mem_ready(mem_ready), .mem_req(mem_req),
        .PCWrite(PCWrite), .IRWrite(IRWrite), .RegWrite(RegWrite),
        .MemWrite(MemWrite), .AdrSrc(AdrSrc), .ULASrcA(ULASrcA),
        .ULASrcB(ULASrcB), .ResultSrc(ResultSrc), .ImmSrc(ImmSrc),
        .ULAControl(ULAControl), .instr_done(instr_done),
        .instr_count(instr_count), .trap(trap)
    );

    always #5 clk = ~clk;

    typedef struct {
        string         nm;
        logic [18:0]   ctl;
        logic [CW-1:0] cnt;
    } exp_t;

    exp_t          sb[$];
    int            n_cmp = 0;
    int            n_err = 0;
    logic [CW-1:0] exp_cnt = '0;

    // {mem_req,PCWrite,IRWrite,RegWrite,MemWrite,AdrSrc,A,B,Res,Imm,ULA,done,trap}
    function automatic logic [18:0] v(input logic rq, pw, iw, rw, mw, ad,
                                      input logic [1:0] a, b, res, imm,
                                      input logic [2:0] ula,
                                      input logic dn, tr);
        return {rq, pw, iw, rw, mw, ad, a, b, res, imm, ula, dn, tr};
    endfunction

    function automatic logic [18:0] e_f(input logic mr);
        return v(1, mr, mr, 0, 0, 0, 2'b00, 2'b10, 2'b10, 2'b00, 3'b000, 0, 0);
    endfunction
    function automatic logic [18:0] e_d(input logic [1:0] imm);
        return v(0, 0, 0, 0, 0, 0, 2'b01, 2'b01, 2'b00, imm, 3'b000, 0, 0);
    endfunction
    function automatic logic [18:0] e_er(input logic [2:0] ula);
        return v(0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b00, 2'b00, ula, 0, 0);
    endfunction
    function automatic logic [18:0] e_ei();
        return v(0, 0, 0, 0, 0, 0, 2'b10, 2'b01, 2'b00, 2'b00, 3'b000, 0, 0);
    endfunction
    function automatic logic [18:0] e_awb();
        return v(0, 0, 0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 1, 0);
    endfunction
    function automatic logic [18:0] e_ma(input logic [1:0] imm);
        return v(0, 0, 0, 0, 0, 0, 2'b10, 2'b01, 2'b00, imm, 3'b000, 0, 0);
    endfunction
    function automatic logic [18:0] e_mr();
        return v(1, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 0, 0);
    endfunction
    function automatic logic [18:0] e_mwb();
        return v(0, 0, 0, 1, 0, 0, 2'b00, 2'b00, 2'b01, 2'b00, 3'b000, 1, 0);
    endfunction
    function automatic logic [18:0] e_mw(input logic mr);
        return v(1, 0, 0, 0, 1, 1, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, mr, 0);
    endfunction
    function automatic logic [18:0] e_br(input logic z);
        return v(0, z, 0, 0, 0, 0, 2'b10, 2'b00, 2'b00, 2'b00, 3'b001, 1, 0);
    endfunction
    function automatic logic [18:0] e_tr();
        return v(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 0, 1);
    endfunction
    function automatic logic [18:0] e_z();
        return '0;
    endfunction

    // One clock cycle: drive inputs, queue expectation, advance to next edge.
    task automatic cyc(input string nm, input logic [18:0] e,
                       input logic mr, input logic z);
        exp_t x;
        mem_ready = mr;
        Zero      = z;
        x.nm  = nm;
        x.ctl = e;
        x.cnt = exp_cnt;
        sb.push_back(x);
        if (e[1]) exp_cnt = exp_cnt + 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic set_ir(input logic [6:0] op, input logic [2:0] f3,
                          input logic [6:0] f7);
        OP = op; Funct3 = f3; Funct7 = f7;
    endtask

    // Monitor: checks every cycle that has a queued expectation.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t x;
            logic [18:0] act;
            x = sb.pop_front();
            act = {mem_req, PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc,
                   ULASrcA, ULASrcB, ResultSrc, ImmSrc, ULAControl,
                   instr_done, trap};
            n_cmp++;
            if (act !== x.ctl || instr_count !== x.cnt) begin
                n_err++;
                $display("FAIL %s: got ctl=%b cnt=%0d, expected ctl=%b cnt=%0d",
                         x.nm, act, instr_count, x.ctl, x.cnt);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    logic [2:0] rf3 [6];
    logic [6:0] rf7 [6];
    logic [2:0] rula[6];

    initial begin
        rf3[0] = 3'b000; rf7[0] = 7'b0000000; rula[0] = 3'b000; // ADD
        rf3[1] = 3'b000; rf7[1] = 7'b0100000; rula[1] = 3'b001; // SUB
        rf3[2] = 3'b111; rf7[2] = 7'b0000000; rula[2] = 3'b010; // AND
        rf3[3] = 3'b110; rf7[3] = 7'b0000000; rula[3] = 3'b011; // OR
        rf3[4] = 3'b100; rf7[4] = 7'b0000000; rula[4] = 3'b100; // XOR
        rf3[5] = 3'b010; rf7[5] = 7'b0000000; rula[5] = 3'b101; // SLT

        rst_n = 1'b0; mem_ready = 1'b0; Zero = 1'b0;
        set_ir(7'b0110011, 3'b000, 7'b0000000);
        @(posedge clk); #1;

        // Reset held: everything quiet even with mem_ready high
        cyc("reset0", e_z(), 1, 0);
        cyc("reset1", e_z(), 1, 0);
        rst_n = 1'b1;

        // R-type operations
        for (int i = 0; i < 6; i++) begin
            set_ir(7'b0110011, rf3[i], rf7[i]);
            cyc("r_fetch",  e_f(1),        1, 0);
            cyc("r_decode", e_d(2'b00),    1, 0);
            cyc("r_exec",   e_er(rula[i]), 1, 0);
            cyc("r_wb",     e_awb(),       1, 0);
        end

        // ADDI, with one fetch wait cycle
        set_ir(7'b0010011, 3'b000, 7'b0000000);
        cyc("addi_fwait", e_f(0),     0, 0);
        cyc("addi_fetch", e_f(1),     1, 0);
        cyc("addi_dec",   e_d(2'b00), 1, 0);
        cyc("addi_exec",  e_ei(),     1, 0);
        cyc("addi_wb",    e_awb(),    1, 0);

        // LB with two wait cycles in MEM_RD
        set_ir(7'b0000011, 3'b000, 7'b0000000);
        cyc("lb_fetch", e_f(1),      1, 0);
        cyc("lb_dec",   e_d(2'b00),  1, 0);
        cyc("lb_adr",   e_ma(2'b00), 1, 0);
        cyc("lb_rd0",   e_mr(),      0, 0);
        cyc("lb_rd1",   e_mr(),      0, 0);
        cyc("lb_rd2",   e_mr(),      1, 0);
        cyc("lb_wb",    e_mwb(),     1, 0);

        // SB, no wait
        set_ir(7'b0100011, 3'b000, 7'b0000000);
        cyc("sb_fetch", e_f(1),      1, 0);
        cyc("sb_dec",   e_d(2'b01),  1, 0);
        cyc("sb_adr",   e_ma(2'b01), 1, 0);
        cyc("sb_wr",    e_mw(1),     1, 0);

        // BEQ taken then not taken
        set_ir(7'b1100011, 3'b000, 7'b0000000);
        cyc("beq1_fetch", e_f(1),     1, 1);
        cyc("beq1_dec",   e_d(2'b10), 1, 1);
        cyc("beq1_br",    e_br(1),    1, 1);
        cyc("beq0_fetch", e_f(1),     1, 0);
        cyc("beq0_dec",   e_d(2'b10), 1, 0);
        cyc("beq0_br",    e_br(0),    1, 0);

        // SB interrupted by reset during the MEM_WR wait
        set_ir(7'b0100011, 3'b000, 7'b0000000);
        cyc("sbr_fetch", e_f(1),      1, 0);
        cyc("sbr_dec",   e_d(2'b01),  1, 0);
        cyc("sbr_adr",   e_ma(2'b01), 1, 0);
        cyc("sbr_wait",  e_mw(0),     0, 0);
        rst_n = 1'b0;
        exp_cnt = '0;
        cyc("sbr_rst0", e_z(), 0, 0);
        cyc("sbr_rst1", e_z(), 1, 0);
        rst_n = 1'b1;
        cyc("sbr_restart", e_f(0), 0, 0);

        // 2^CW ADDIs: counter wraps back to 0
        set_ir(7'b0010011, 3'b000, 7'b0000000);
        for (int i = 0; i < 16; i++) begin
            cyc("wrap_fetch", e_f(1),     1, 0);
            cyc("wrap_dec",   e_d(2'b00), 1, 0);
            cyc("wrap_exec",  e_ei(),     1, 0);
            cyc("wrap_wb",    e_awb(),    1, 0);
        end

        // One ADDI so reset has a nonzero count to clear, then illegal R-type
        cyc("pre_fetch", e_f(1),     1, 0);
        cyc("pre_dec",   e_d(2'b00), 1, 0);
        cyc("pre_exec",  e_ei(),     1, 0);
        cyc("pre_wb",    e_awb(),    1, 0);
        set_ir(7'b0110011, 3'b000, 7'b1111111);
        cyc("trap_fetch", e_f(1),     1, 0);
        cyc("trap_dec",   e_d(2'b00), 1, 0);
        for (int i = 0; i < 20; i++)
            cyc("trap_hold", e_tr(), 1, 1);
        rst_n = 1'b0;
        exp_cnt = '0;
        cyc("trap_rst", e_z(), 1, 0);
        rst_n = 1'b1;

        // Unsupported opcode also traps; reset then a normal ADD
        set_ir(7'b1111111, 3'b000, 7'b0000000);
        cyc("badop_fetch", e_f(1),     1, 0);
        cyc("badop_dec",   e_d(2'b00), 1, 0);
        cyc("badop_trap0", e_tr(),     1, 0);
        cyc("badop_trap1", e_tr(),     0, 0);
        rst_n = 1'b0;
        cyc("badop_rst", e_z(), 1, 0);
        rst_n = 1'b1;
        set_ir(7'b0110011, 3'b000, 7'b0000000);
        cyc("add_fetch", e_f(1),        1, 0);
        cyc("add_dec",   e_d(2'b00),    1, 0);
        cyc("add_exec",  e_er(3'b000),  1, 0);
        cyc("add_wb",    e_awb(),       1, 0);
        cyc("add_next",  e_f(0),        0, 0);

        for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d expectations left unchecked, required 0",
                     sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 Parameter: COUNT_W, 16, width of retired-instruction counter.
REQ-002 clk  in  1  single clock; all state changes on rising edge.
REQ-003 rst_n  in  1  asynchronous, active-low reset.
REQ-004 OP  in  7  opcode of instruction register (IR) contents.
REQ-005 Funct3  in  3  IR funct3 field.
REQ-006 Funct7  in  7  IR funct7 field.
REQ-007 Zero  in  1  ULA zero flag.
REQ-008 mem_ready  in  1  memory completes current access this cycle.
REQ-009 mem_req  out  1  memory access request; held until mem_ready.
REQ-010 PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc  out  1 each  datapath strobes/select (AdrSrc 0=PC, 1=ALUOut).
REQ-011 ULASrcA  out  2  00=PC, 01=OldPC, 10=rs1.  ULASrcB  out  2  00=rs2, 01=imm, 10=const 4.
REQ-012 ResultSrc  out  2  00=ALUOut, 01=mem data, 10=ULA result.  ImmSrc  out  2  00=I, 01=S, 10=B.
REQ-013 ULAControl  out  3  000 add, 001 sub, 010 and, 011 or, 100 xor, 101 slt.
REQ-014 instr_done  out  1  one-cycle pulse in final cycle of each instruction.
REQ-015 instr_count  out  COUNT_W  retired-instruction count.
REQ-016 trap  out  1  high while halted on unsupported instruction.

Function
REQ-017 Supported (OP/Funct3/Funct7): R 0110011/000/0000000 ADD, /000/0100000 SUB, /111 AND, /110 OR, /100 XOR, /010 SLT (R Funct7=0000000 except SUB); ADDI 0010011/000; LB 0000011/000; SB 0100011/000; BEQ 1100011/000.
REQ-018 States: FETCH, DECODE, EXEC_R, EXEC_I, MEM_ADR, MEM_RD, MEM_WB, MEM_WR, ALU_WB, BRANCH, TRAP.
REQ-019 FETCH: mem_req=1, AdrSrc=0, A=00, B=10, add, ResultSrc=10; IRWrite=PCWrite=mem_ready; stay until mem_ready, then DECODE.
REQ-020 DECODE: A=01, B=01, add (branch target to ALUOut), ImmSrc per opcode; next EXEC_R / EXEC_I / MEM_ADR (LB, SB) / BRANCH; unsupported encoding -> TRAP.
REQ-021 EXEC_R: A=10, B=00, ULAControl from funct decode -> ALU_WB. EXEC_I: A=10, B=01, add -> ALU_WB.
REQ-022 ALU_WB: ResultSrc=00, RegWrite=1, instr_done=1 -> FETCH.
REQ-023 MEM_ADR: A=10, B=01, add, ImmSrc 00 (LB) / 01 (SB) -> MEM_RD (LB) or MEM_WR (SB).
REQ-024 MEM_RD: mem_req=1, AdrSrc=1; wait for mem_ready -> MEM_WB. MEM_WB: ResultSrc=01, RegWrite=1, instr_done=1 -> FETCH.
REQ-025 MEM_WR: mem_req=1, AdrSrc=1, MemWrite=1 held until mem_ready; on mem_ready instr_done=1 -> FETCH.
REQ-026 BRANCH: A=10, B=00, sub, ResultSrc=00, PCWrite=Zero (combinational on Zero), instr_done=1 -> FETCH.
REQ-027 TRAP: trap=1, all strobes and mem_req 0; exit only by reset.
REQ-028 Latency with mem_ready=1: BEQ 3, R/ADDI/SB 4, LB 5 cycles; each mem_ready=0 cycle in a wait state adds 1.
REQ-029 Strobes (PCWrite, IRWrite, RegWrite, MemWrite, mem_req) SHALL be 0 in every state/condition not listed; unused selects drive 0.
REQ-030 instr_count increments by 1 on each instr_done, wraps from all-ones to 0; TRAP entry not counted.

Reset
REQ-031 rst_n low: state=FETCH, instr_count=0, trap=0, immediately and asynchronously.
REQ-032 While rst_n low all strobes and mem_req SHALL be 0; first FETCH request in first cycle after release.
REQ-033 Reset mid-instruction (incl. during memory wait) SHALL abandon it with no further write strobe.

Structure
REQ-034 Package mc_ctrl_pkg: state enum, opcode constants, ULAControl codes, ImmSrc codes, ULASrcA/B and ResultSrc select codes.
REQ-035 Sub-module ula_decoder: combinational Funct3/Funct7 -> ULAControl plus illegal flag for R-type.

Verification
REQ-036 ADD (OP 0110011, F3 000, F7 0000000), mem_ready=1 -> FETCH,DECODE,EXEC_R(ULAControl 000),ALU_WB(RegWrite=1); instr_done cycle 4; instr_count=1.
REQ-037 LB with mem_ready low 2 cycles in MEM_RD -> mem_req/AdrSrc=1 held 3 cycles, RegWrite with ResultSrc=01 in cycle 7.
REQ-038 BEQ with Zero=1 then Zero=0 -> PCWrite=1 in BRANCH first time, 0 second; each 3 cycles.
REQ-039 OP 0110011, F3 000, F7 1111111 -> TRAP after DECODE; trap=1, no strobes for 20 cycles; reset clears.
REQ-040 SB with rst_n pulsed low during MEM_WR wait -> MemWrite drops at once; restart in FETCH, instr_count=0.
REQ-041 Preload-free count: 2^COUNT_W ADDI instructions (COUNT_W=4) -> instr_count wraps 15 -> 0.
